// File: rtl/full_adder_demux.sv
// 1-bit full adder decoded through a 1:8 demux tree.
// Combinational sum/cout plus registered copies and a self-check flag.

module full_adder_demux_cell (
  input  logic d,
  input  logic s,
  output logic y0,
  output logic y1
);

  // Route data to y1 when select is high, otherwise to y0
  always_comb begin
    y0 = d & ~s;
    y1 = d & s;
  end

endmodule

module full_adder_demux (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       a,
  input  logic       b,
  input  logic       cin,
  output logic       sum,
  output logic       cout,
  output logic [7:0] minterm,
  output logic       sum_q,
  output logic       cout_q,
  output logic       err_q
);

  logic [1:0] lvl_a;
  logic [3:0] lvl_b;
  logic [7:0] lvl_c;
  logic [1:0] ref_cnt;
  logic       one_hot;
  logic       err_d;

  full_adder_demux_cell u_cell_a (
    .d  (1'b1),
    .s  (a),
    .y0 (lvl_a[0]),
    .y1 (lvl_a[1])
  );

  for (genvar i = 0; i < 2; i++) begin : g_stage_b
    full_adder_demux_cell u_cell_b (
      .d  (lvl_a[i]),
      .s  (b),
      .y0 (lvl_b[2*i]),
      .y1 (lvl_b[2*i+1])
    );
  end

  for (genvar j = 0; j < 4; j++) begin : g_stage_c
    full_adder_demux_cell u_cell_c (
      .d  (lvl_b[j]),
      .s  (cin),
      .y0 (lvl_c[2*j]),
      .y1 (lvl_c[2*j+1])
    );
  end

  assign minterm = lvl_c;

  // Sum and carry as OR of their minterms
  always_comb begin
    sum  = minterm[1] | minterm[2]
         | minterm[4] | minterm[7];
    cout = minterm[3] | minterm[5]
         | minterm[6] | minterm[7];
  end

  // Arithmetic reference and one-hot check for the error flag
  always_comb begin
    ref_cnt = {1'b0, a} + {1'b0, b}
            + {1'b0, cin};
    one_hot = (|minterm)
            && ((minterm & (minterm - 8'd1))
                == 8'd0);
    err_d   = ({cout, sum} != ref_cnt)
            | ~one_hot;
  end

  // Capture results and check flag each cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q  <= 1'b0;
      cout_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      sum_q  <= sum;
      cout_q <= cout;
      err_q  <= err_d;
    end
  end

endmodule

// File: tb/tb_full_adder_demux.sv
// Self-checking bench for full_adder_demux.
// Scenario tasks with a scoreboard queue for registered outputs.

module tb_full_adder_demux;

  logic       clk;
  logic       rst_n;
  logic       a;
  logic       b;
  logic       cin;
  logic       sum;
  logic       cout;
  logic [7:0] minterm;
  logic       sum_q;
  logic       cout_q;
  logic       err_q;

  int tests;
  int fails;

  logic [1:0] sb[$];

  full_adder_demux dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .a       (a),
    .b       (b),
    .cin     (cin),
    .sum     (sum),
    .cout    (cout),
    .minterm (minterm),
    .sum_q   (sum_q),
    .cout_q  (cout_q),
    .err_q   (err_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [1:0] model(
    input logic [2:0] v
  );
    logic [1:0] c;
    c = {1'b0, v[2]} + {1'b0, v[1]}
      + {1'b0, v[0]};
    return c;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    a = 1'b1;
    b = 1'b1;
    cin = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if ({sum_q, cout_q, err_q} !== 3'b000) begin
      fails++;
      $display("FAIL reset_regs got=%b exp=000",
               {sum_q, cout_q, err_q});
    end
    tests++;
    if ({sum, cout} !== 2'b11) begin
      fails++;
      $display("FAIL reset_comb got=%b exp=11",
               {sum, cout});
    end
  endtask

  task automatic test_comb();
    logic [2:0] v;
    logic [1:0] e;
    logic [7:0] oh;
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      {a, b, cin} = v;
      #5;
      e = model(v);
      oh = 8'b1 << i;
      tests++;
      if ({sum, cout} !== {e[0], e[1]}) begin
        fails++;
        $display("FAIL comb sel=%0d got=%b exp=%b",
                 i, {sum, cout}, {e[0], e[1]});
      end
      tests++;
      if (minterm !== oh) begin
        fails++;
        $display("FAIL onehot sel=%0d got=%b exp=%b",
                 i, minterm, oh);
      end
    end
  endtask

  task automatic test_latency();
    @(negedge clk);
    rst_n = 1'b1;
    {a, b, cin} = 3'b001;
    @(posedge clk);
    #1;
    tests++;
    if ({cout_q, sum_q} !== 2'b01) begin
      fails++;
      $display("FAIL lat_pre got=%b exp=01",
               {cout_q, sum_q});
    end
    @(negedge clk);
    {a, b, cin} = 3'b011;
    #1;
    tests++;
    if ({cout_q, sum_q} !== 2'b01) begin
      fails++;
      $display("FAIL lat_hold got=%b exp=01",
               {cout_q, sum_q});
    end
    @(posedge clk);
    #1;
    tests++;
    if ({cout_q, sum_q} !== 2'b10) begin
      fails++;
      $display("FAIL lat_post got=%b exp=10",
               {cout_q, sum_q});
    end
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    {a, b, cin} = 3'b100;
    @(posedge clk);
    #1;
    tests++;
    if (sum_q !== 1'b1) begin
      fails++;
      $display("FAIL midrst_pre got=%b exp=1",
               sum_q);
    end
    #1;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({sum_q, cout_q, err_q} !== 3'b000) begin
      fails++;
      $display("FAIL midrst_clr got=%b exp=000",
               {sum_q, cout_q, err_q});
    end
    tests++;
    if ({sum, cout} !== 2'b10) begin
      fails++;
      $display("FAIL midrst_comb got=%b exp=10",
               {sum, cout});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    logic [2:0] v;
    logic [1:0] e;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      v = 3'($urandom_range(0, 7));
      {a, b, cin} = v;
      sb.push_back(model(v));
      @(posedge clk);
      #1;
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL rand_sb_empty idx=%0d", i);
      end else begin
        e = sb.pop_front();
        if ({cout_q, sum_q} !== e
            || err_q !== 1'b0) begin
          fails++;
          $display("FAIL rand idx=%0d got=%b err=%b exp=%b err=0",
                   i, {cout_q, sum_q}, err_q, e);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] v;
    logic [1:0] e;
    for (int i = 7; i >= 0; i--) begin
      @(negedge clk);
      v = 3'(i);
      {a, b, cin} = v;
      sb.push_back(model(v));
      @(posedge clk);
      #1;
      e = sb.pop_front();
      tests++;
      if ({cout_q, sum_q} !== e) begin
        fails++;
        $display("FAIL b2b sel=%0d got=%b exp=%b",
                 i, {cout_q, sum_q}, e);
      end
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    a = 1'b0;
    b = 1'b0;
    cin = 1'b0;
    test_reset();
    test_comb();
    test_latency();
    test_mid_reset();
    test_random();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
